// File: rtl/operate_pkg.sv
// Shared definitions for the Operate core and its run controller:
// PC/address width, run-controller state encoding and result status codes.
package operate_pkg;

    localparam int unsigned ARG_SIZE = 8;
    localparam int unsigned CYCLE_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_RUN    = 3'd2,
        S_ACK    = 3'd3,
        S_FLUSH  = 3'd4,
        S_RESULT = 3'd5
    } run_state_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_TIMEOUT = 2'd1,
        ST_ABORT   = 2'd2
    } run_status_e;

endpackage

// File: rtl/operate_run_ctrl.sv
// Run controller for one Operate core.
// Accepts a host run request, drives the core start/ack handshake, enforces a
// RUN-cycle watchdog and host abort, and reports a latched result.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   go/abort/hostAck  host run request, abort request, result consume
//   maxCycles         watchdog limit (0 = unlimited), sampled when go is accepted
//   busy/resultValid  run in progress / result available
//   status            0 OK, 1 TIMEOUT, 2 ABORT
//   cycleCount        RUN cycles elapsed (saturating)
//   wrCount           core data writes during RUN (saturating)
//   haltPc            core PC captured when done is first seen
//   coreReset/coreStart/coreAck  controls to the core
//   coreDone/corePc/coreWrEn     observation taps from the core
module operate_run_ctrl #(
    parameter int unsigned ARG_SIZE = operate_pkg::ARG_SIZE,
    parameter int unsigned CYCLE_W  = operate_pkg::CYCLE_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                go,
    input  logic                abort,
    input  logic                hostAck,
    input  logic [CYCLE_W-1:0]  maxCycles,
    output logic                busy,
    output logic                resultValid,
    output logic [1:0]          status,
    output logic [CYCLE_W-1:0]  cycleCount,
    output logic [CYCLE_W-1:0]  wrCount,
    output logic [ARG_SIZE-1:0] haltPc,
    output logic                coreReset,
    output logic                coreStart,
    output logic                coreAck,
    input  logic                coreDone,
    input  logic [ARG_SIZE-1:0] corePc,
    input  logic                coreWrEn
);

    import operate_pkg::*;

    // Increment by one when enabled, sticking at all-ones.
    function automatic logic [CYCLE_W-1:0] sat_inc(input logic [CYCLE_W-1:0] v,
                                                   input logic en);
        if (en && (v != '1)) begin
            return v + CYCLE_W'(1);
        end
        return v;
    endfunction

    run_state_e          state_q,  state_d;
    run_status_e         status_q, status_d;
    logic [CYCLE_W-1:0]  limit_q,  limit_d;
    logic [CYCLE_W-1:0]  cyc_q,    cyc_d;
    logic [CYCLE_W-1:0]  wr_q,     wr_d;
    logic [ARG_SIZE-1:0] pc_q,     pc_d;
    logic                start_q,  start_d;
    logic                ack_q,    ack_d;

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        limit_d  = limit_q;
        cyc_d    = cyc_q;
        wr_d     = wr_q;
        pc_d     = pc_q;
        start_d  = 1'b0;
        ack_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d  = S_START;
                    limit_d  = maxCycles;
                    cyc_d    = '0;
                    wr_d     = '0;
                    pc_d     = '0;
                    status_d = ST_OK;
                    start_d  = 1'b1;
                end
            end
            S_START: begin
                if (abort) begin
                    state_d  = S_FLUSH;
                    status_d = ST_ABORT;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // The cycle that ends the run is still counted, so the
                // limit is compared against the post-increment value.
                cyc_d = sat_inc(cyc_q, 1'b1);
                wr_d  = sat_inc(wr_q, coreWrEn);
                if (coreDone) begin
                    pc_d    = corePc;
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                end else if (abort) begin
                    state_d  = S_FLUSH;
                    status_d = ST_ABORT;
                end else if ((limit_q != '0) && (cyc_d == limit_q)) begin
                    state_d  = S_FLUSH;
                    status_d = ST_TIMEOUT;
                end
            end
            S_ACK: begin
                if (coreDone) begin
                    ack_d = 1'b1;
                end else begin
                    state_d  = S_RESULT;
                    status_d = ST_OK;
                end
            end
            S_FLUSH: begin
                state_d = S_RESULT;
            end
            S_RESULT: begin
                if (hostAck) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            status_q <= ST_OK;
            limit_q  <= '0;
            cyc_q    <= '0;
            wr_q     <= '0;
            pc_q     <= '0;
            start_q  <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            limit_q  <= limit_d;
            cyc_q    <= cyc_d;
            wr_q     <= wr_d;
            pc_q     <= pc_d;
            start_q  <= start_d;
            ack_q    <= ack_d;
        end
    end

    assign busy        = (state_q != S_IDLE) && (state_q != S_RESULT);
    assign resultValid = (state_q == S_RESULT);
    assign status      = status_q;
    assign cycleCount  = cyc_q;
    assign wrCount     = wr_q;
    assign haltPc      = pc_q;
    assign coreStart   = start_q;
    assign coreAck     = ack_q;
    // Core is held in reset with the controller and pulsed during FLUSH.
    assign coreReset   = reset | (state_q == S_FLUSH);

endmodule

// File: tb/tb_operate_run_ctrl.sv
// Directed self-checking bench for operate_run_ctrl.
module tb_operate_run_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        go = 1'b0;
    logic        abort = 1'b0;
    logic        hostAck = 1'b0;
    logic [15:0] maxCycles = '0;
    logic        busy;
    logic        resultValid;
    logic [1:0]  status;
    logic [15:0] cycleCount;
    logic [15:0] wrCount;
    logic [7:0]  haltPc;
    logic        coreReset;
    logic        coreStart;
    logic        coreAck;
    logic        coreDone = 1'b0;
    logic [7:0]  corePc = '0;
    logic        coreWrEn = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    operate_run_ctrl dut (
        .clk(clk), .reset(reset), .go(go), .abort(abort), .hostAck(hostAck),
        .maxCycles(maxCycles), .busy(busy), .resultValid(resultValid),
        .status(status), .cycleCount(cycleCount), .wrCount(wrCount),
        .haltPc(haltPc), .coreReset(coreReset), .coreStart(coreStart),
        .coreAck(coreAck), .coreDone(coreDone), .corePc(corePc),
        .coreWrEn(coreWrEn)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are read 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0h want 0", busy); end
        n_tests++; if (resultValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0h want 0", resultValid); end
        n_tests++; if (coreStart !== 1'b0 || coreAck !== 1'b0) begin n_fail++; $display("FAIL reset_start_ack: got %0h/%0h want 0/0", coreStart, coreAck); end
        n_tests++; if (status !== 2'd0 || cycleCount !== 16'd0 || wrCount !== 16'd0 || haltPc !== 8'd0) begin
            n_fail++; $display("FAIL reset_regs: got st=%0h cc=%0h wr=%0h pc=%0h want all 0", status, cycleCount, wrCount, haltPc); end
        n_tests++; if (coreReset !== 1'b1) begin n_fail++; $display("FAIL reset_corereset: got %0h want 1", coreReset); end
        reset = 1'b0;
        step();
        n_tests++; if (coreReset !== 1'b0) begin n_fail++; $display("FAIL reset_release: got %0h want 0", coreReset); end
    endtask

    task automatic test_normal();
        maxCycles = 16'd0;
        go = 1'b1;
        step();
        go = 1'b0;
        n_tests++; if (coreStart !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL normal_start: got start=%0h busy=%0h want 1/1", coreStart, busy); end
        step();
        n_tests++; if (coreStart !== 1'b0) begin n_fail++; $display("FAIL normal_start_pulse: got %0h want 0", coreStart); end
        for (int k = 1; k <= 6; k++) begin
            coreWrEn = (k == 2 || k == 4);
            coreDone = (k == 6);
            corePc   = (k == 6) ? 8'h05 : 8'h40 + 8'(k);
            step();
        end
        // ACK: done still high, pc/wrEn changes must not be recorded
        corePc   = 8'h77;
        coreWrEn = 1'b1;
        n_tests++; if (coreAck !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL normal_ack: got ack=%0h busy=%0h want 1/1", coreAck, busy); end
        n_tests++; if (cycleCount !== 16'd6 || wrCount !== 16'd2 || haltPc !== 8'h05) begin
            n_fail++; $display("FAIL normal_ack_regs: got cc=%0d wr=%0d pc=%0h want 6/2/05", cycleCount, wrCount, haltPc); end
        step();
        n_tests++; if (coreAck !== 1'b1 || resultValid !== 1'b0) begin n_fail++; $display("FAIL normal_ack_hold: got ack=%0h valid=%0h want 1/0", coreAck, resultValid); end
        coreDone = 1'b0;
        coreWrEn = 1'b0;
        step();
        n_tests++; if (resultValid !== 1'b1 || coreAck !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL normal_result: got valid=%0h ack=%0h busy=%0h want 1/0/0", resultValid, coreAck, busy); end
        n_tests++; if (status !== 2'd0 || cycleCount !== 16'd6 || wrCount !== 16'd2 || haltPc !== 8'h05) begin
            n_fail++; $display("FAIL normal_result_regs: got st=%0h cc=%0d wr=%0d pc=%0h want 0/6/2/05", status, cycleCount, wrCount, haltPc); end
        step();
        n_tests++; if (resultValid !== 1'b1 || cycleCount !== 16'd6) begin n_fail++; $display("FAIL normal_result_hold: got valid=%0h cc=%0d want 1/6", resultValid, cycleCount); end
        hostAck = 1'b1;
        step();
        hostAck = 1'b0;
        n_tests++; if (resultValid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL normal_idle: got valid=%0h busy=%0h want 0/0", resultValid, busy); end
    endtask

    task automatic test_timeout();
        maxCycles = 16'd4;
        go = 1'b1;
        step();
        go = 1'b0;
        maxCycles = 16'd9;  // changing the limit after acceptance has no effect
        step();
        for (int k = 1; k <= 3; k++) begin
            step();
            n_tests++; if (coreReset !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL timeout_run%0d: got crst=%0h busy=%0h want 0/1", k, coreReset, busy); end
        end
        step();
        n_tests++; if (coreReset !== 1'b1 || cycleCount !== 16'd4 || status !== 2'd1) begin
            n_fail++; $display("FAIL timeout_flush: got crst=%0h cc=%0d st=%0h want 1/4/1", coreReset, cycleCount, status); end
        step();
        n_tests++; if (coreReset !== 1'b0 || resultValid !== 1'b1) begin n_fail++; $display("FAIL timeout_result: got crst=%0h valid=%0h want 0/1", coreReset, resultValid); end
        n_tests++; if (status !== 2'd1 || cycleCount !== 16'd4 || wrCount !== 16'd0) begin
            n_fail++; $display("FAIL timeout_regs: got st=%0h cc=%0d wr=%0d want 1/4/0", status, cycleCount, wrCount); end
        hostAck = 1'b1;
        step();
        hostAck = 1'b0;
    endtask

    task automatic test_abort();
        maxCycles = 16'd0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_tests++; if (busy !== 1'b0 || resultValid !== 1'b0 || coreReset !== 1'b0) begin
            n_fail++; $display("FAIL abort_idle: got busy=%0h valid=%0h crst=%0h want 0/0/0", busy, resultValid, coreReset); end
        go = 1'b1;
        step();
        go = 1'b0;
        step();
        step();
        step();
        abort = 1'b1;  // RUN cycle 3
        step();
        abort = 1'b0;
        n_tests++; if (coreReset !== 1'b1 || status !== 2'd2 || cycleCount !== 16'd3) begin
            n_fail++; $display("FAIL abort_run_flush: got crst=%0h st=%0h cc=%0d want 1/2/3", coreReset, status, cycleCount); end
        step();
        n_tests++; if (resultValid !== 1'b1 || status !== 2'd2 || cycleCount !== 16'd3) begin
            n_fail++; $display("FAIL abort_run_result: got valid=%0h st=%0h cc=%0d want 1/2/3", resultValid, status, cycleCount); end
        hostAck = 1'b1;
        step();
        hostAck = 1'b0;
        // abort while coreStart is being driven
        go = 1'b1;
        step();
        go = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_tests++; if (coreReset !== 1'b1 || status !== 2'd2 || cycleCount !== 16'd0) begin
            n_fail++; $display("FAIL abort_start: got crst=%0h st=%0h cc=%0d want 1/2/0", coreReset, status, cycleCount); end
        step();
        hostAck = 1'b1;
        step();
        hostAck = 1'b0;
    endtask

    task automatic test_done_at_limit();
        maxCycles = 16'd5;
        go = 1'b1;
        step();
        go = 1'b0;
        step();
        for (int k = 1; k <= 4; k++) step();
        coreDone = 1'b1;
        corePc = 8'h33;
        step();
        n_tests++; if (coreAck !== 1'b1 || coreReset !== 1'b0 || cycleCount !== 16'd5) begin
            n_fail++; $display("FAIL limit_done_ack: got ack=%0h crst=%0h cc=%0d want 1/0/5", coreAck, coreReset, cycleCount); end
        coreDone = 1'b0;
        step();
        n_tests++; if (resultValid !== 1'b1 || status !== 2'd0 || cycleCount !== 16'd5 || haltPc !== 8'h33) begin
            n_fail++; $display("FAIL limit_done_result: got valid=%0h st=%0h cc=%0d pc=%0h want 1/0/5/33", resultValid, status, cycleCount, haltPc); end
        hostAck = 1'b1;
        step();
        hostAck = 1'b0;
    endtask

    task automatic test_ignored_go();
        maxCycles = 16'd0;
        go = 1'b1;
        step();
        go = 1'b0;
        step();
        go = 1'b1;
        hostAck = 1'b1;
        step();
        go = 1'b0;
        hostAck = 1'b0;
        n_tests++; if (busy !== 1'b1 || coreStart !== 1'b0 || cycleCount !== 16'd1) begin
            n_fail++; $display("FAIL ign_go_run: got busy=%0h start=%0h cc=%0d want 1/0/1", busy, coreStart, cycleCount); end
        coreWrEn = 1'b1;
        step();
        coreWrEn = 1'b0;
        coreDone = 1'b1;
        corePc = 8'h09;
        step();
        coreDone = 1'b0;
        step();
        go = 1'b1;
        step();
        go = 1'b0;
        n_tests++; if (resultValid !== 1'b1 || coreStart !== 1'b0 || cycleCount !== 16'd3 || wrCount !== 16'd1 || haltPc !== 8'h09) begin
            n_fail++; $display("FAIL ign_go_result: got valid=%0h start=%0h cc=%0d wr=%0d pc=%0h want 1/0/3/1/09", resultValid, coreStart, cycleCount, wrCount, haltPc); end
        step();
        n_tests++; if (busy !== 1'b0 || resultValid !== 1'b1) begin n_fail++; $display("FAIL ign_go_no_queue: got busy=%0h valid=%0h want 0/1", busy, resultValid); end
        hostAck = 1'b1;
        step();
        hostAck = 1'b0;
        go = 1'b1;
        step();
        go = 1'b0;
        n_tests++; if (coreStart !== 1'b1 || cycleCount !== 16'd0 || wrCount !== 16'd0 || haltPc !== 8'd0 || status !== 2'd0) begin
            n_fail++; $display("FAIL fresh_clear: got start=%0h cc=%0d wr=%0d pc=%0h st=%0h want 1/0/0/00/0", coreStart, cycleCount, wrCount, haltPc, status); end
        step();
        coreDone = 1'b1;
        corePc = 8'h02;
        step();
        coreDone = 1'b0;
        step();
        n_tests++; if (resultValid !== 1'b1 || cycleCount !== 16'd1 || wrCount !== 16'd0 || haltPc !== 8'h02) begin
            n_fail++; $display("FAIL fresh_result: got valid=%0h cc=%0d wr=%0d pc=%0h want 1/1/0/02", resultValid, cycleCount, wrCount, haltPc); end
        hostAck = 1'b1;
        step();
        hostAck = 1'b0;
    endtask

    task automatic test_reset_in_ack();
        go = 1'b1;
        step();
        go = 1'b0;
        step();
        coreDone = 1'b1;
        corePc = 8'h44;
        step();
        n_tests++; if (coreAck !== 1'b1) begin n_fail++; $display("FAIL rst_ack_pre: got ack=%0h want 1", coreAck); end
        reset = 1'b1;
        step();
        n_tests++; if (coreAck !== 1'b0 || resultValid !== 1'b0 || busy !== 1'b0 || coreReset !== 1'b1) begin
            n_fail++; $display("FAIL rst_ack_ctrl: got ack=%0h valid=%0h busy=%0h crst=%0h want 0/0/0/1", coreAck, resultValid, busy, coreReset); end
        n_tests++; if (cycleCount !== 16'd0 || wrCount !== 16'd0 || haltPc !== 8'd0 || status !== 2'd0) begin
            n_fail++; $display("FAIL rst_ack_regs: got cc=%0d wr=%0d pc=%0h st=%0h want 0/0/00/0", cycleCount, wrCount, haltPc, status); end
        reset = 1'b0;
        coreDone = 1'b0;
        step();
        n_tests++; if (coreReset !== 1'b0 || busy !== 1'b0 || resultValid !== 1'b0) begin
            n_fail++; $display("FAIL rst_ack_after: got crst=%0h busy=%0h valid=%0h want 0/0/0", coreReset, busy, resultValid); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_timeout();
        test_abort();
        test_done_at_limit();
        test_ignored_go();
        test_reset_in_ack();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
